// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and line-fill types shared by ahb_line_fill
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DONE
    } fill_state_e;

    localparam int LINE_W = 128;

endpackage

// File: rtl/ahb_line_fill.sv
// ahb_line_fill: I-cache line refill via a 4-beat AHB-Lite read burst; CRITICAL_WORD_FIRST_EN selects WRAP4 critical-word-first
module ahb_line_fill
    import ahb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_req,
    input  logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_WORDS*32-1:0] mem_data_out,
    output logic                     mem_ready,
    output logic                     mem_err,
    output logic [ADDR_W-1:0]        haddr,
    output logic [1:0]               htrans,
    output logic [2:0]               hburst,
    output logic [2:0]               hsize,
    output logic                     hwrite,
    input  logic [31:0]              hrdata,
    input  logic                     hready,
    input  logic                     hresp
);

    fill_state_e               state;
    htrans_e                   ht;
    logic [ADDR_W-5:0]         base;
    logic [1:0]                start;
    logic [1:0]                start_word;
    logic [2:0]                acnt;
    logic [2:0]                dcnt;
    logic                      err_seen;
    logic [LINE_WORDS*32-1:0]  line;
    logic [LINE_WORDS*32-1:0]  line_nxt;
    logic [1:0]                dlane;
    logic [1:0]                word_nxt;
    logic                      dpend;
    logic                      addr_unused;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [2:0] BURST_KIND = HBURST_WRAP4;
    assign start_word  = mem_addr[3:2];
    assign addr_unused = ^mem_addr[1:0];
`else
    localparam logic [2:0] BURST_KIND = HBURST_INCR4;
    assign start_word  = 2'b00;
    assign addr_unused = ^mem_addr[3:0];
`endif

    assign htrans = ht;
    assign hsize  = HSIZE_WORD;
    assign hwrite = 1'b0;
    // A data phase is outstanding whenever more addresses were accepted than beats returned
    assign dpend  = (acnt != dcnt);

    // Lane of the beat in its data phase, next wrapped word address, and the line with that beat merged
    always_comb begin
        dlane    = start + dcnt[1:0];
        word_nxt = start + acnt[1:0] + 2'd1;
        line_nxt = line;
        line_nxt[{dlane, 5'd0} +: 32] = hrdata;
    end

    // Fill FSM: issues the pipelined burst, assembles the line and pulses completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            ht           <= HT_IDLE;
            haddr        <= '0;
            hburst       <= HBURST_SINGLE;
            base         <= '0;
            start        <= '0;
            acnt         <= '0;
            dcnt         <= '0;
            err_seen     <= 1'b0;
            line         <= '0;
            mem_data_out <= '0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        state    <= ST_BURST;
                        base     <= mem_addr[ADDR_W-1:4];
                        start    <= start_word;
                        acnt     <= '0;
                        dcnt     <= '0;
                        err_seen <= 1'b0;
                        line     <= '0;
                        ht       <= HT_NONSEQ;
                        haddr    <= {mem_addr[ADDR_W-1:4], start_word, 2'b00};
                        hburst   <= BURST_KIND;
                    end
                end
                ST_BURST: begin
                    if (hready) begin
                        if (dpend && (hresp || err_seen)) begin
                            state        <= ST_DONE;
                            ht           <= HT_IDLE;
                            mem_ready    <= 1'b1;
                            mem_err      <= 1'b1;
                            mem_data_out <= line;
                        end else begin
                            if (dpend) begin
                                line <= line_nxt;
                                dcnt <= dcnt + 3'd1;
                                if (dcnt == 3'd3) begin
                                    state        <= ST_DONE;
                                    mem_ready    <= 1'b1;
                                    mem_data_out <= line_nxt;
                                end
                            end
                            if (ht != HT_IDLE) begin
                                acnt  <= acnt + 3'd1;
                                ht    <= (acnt == 3'd3) ? HT_IDLE : HT_SEQ;
                                haddr <= (acnt == 3'd3) ? haddr : {base, word_nxt, 2'b00};
                            end
                        end
                    end else if (dpend && hresp) begin
                        // First ERROR cycle: cancel the pending address phase in the second cycle
                        ht       <= HT_IDLE;
                        err_seen <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_line_fill.sv
// tb_ahb_line_fill: directed table-driven bench for ahb_line_fill; CRITICAL_WORD_FIRST_EN adds the wrap test
module tb_ahb_line_fill;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_req = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [127:0] mem_data_out;
    logic         mem_ready;
    logic         mem_err;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [2:0]   hsize;
    logic         hwrite;
    logic [31:0]  hrdata = '0;
    logic         hready = 1'b1;
    logic         hresp = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0]  A = 32'h0000_1234;
    localparam logic [31:0]  J = 32'hBAD0_BAD0;
    localparam logic [127:0] L = 128'h44444444_33333333_22222222_11111111;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [2:0] HB = 3'b010;
`else
    localparam logic [2:0] HB = 3'b011;
`endif

    ahb_line_fill dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_err(mem_err),
        .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    // Lane holding beat k of a fill requested at address a
    function automatic logic [1:0] lane(input logic [31:0] a, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
        return a[3:2] + 2'(k);
`else
        return 2'(k);
`endif
    endfunction

    function automatic logic [31:0] ea(input logic [31:0] a, input int k);
        return {a[31:4], lane(a, k), 2'b00};
    endfunction

    // Slave memory: word in lane w reads as (w+1) * 0x11111111
    function automatic logic [31:0] wd(input logic [31:0] a, input int k);
        return 32'h11111111 * (32'(lane(a, k)) + 32'd1);
    endfunction

    typedef struct {
        logic         rst;
        logic         req;
        logic [31:0]  rdata;
        logic [1:0]   ht;
        logic         ca;
        logic [31:0]  ha;
        logic         mr;
        logic         cd;
        logic [127:0] d;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, input logic q, input logic [31:0] rd, input logic [1:0] t,
                                input logic ca, input logic [31:0] ha, input logic mr, input logic cd,
                                input logic [127:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.rdata = rd; v.ht = t; v.ca = ca; v.ha = ha; v.mr = mr; v.cd = cd; v.d = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [1:0] t, input logic [31:0] a);
        chk({nm, " htrans"}, 128'(htrans), 128'(t));
        if (t != 2'b00) chk({nm, " haddr"}, 128'(haddr), 128'(a));
    endtask

    task automatic drv(input logic q, input logic rd, input logic rs, input logic [31:0] dt);
        mem_req = q; mem_addr = A; hready = rd; hresp = rs; hrdata = dt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [127:0] ed;
        // Zero-wait fill, reset mid-burst, back-to-back with req held, req dropped mid-burst
        tv.push_back(mk(1, 1, J,      2'b00, 1, 32'h0,  0, 1, '0));
        tv.push_back(mk(1, 0, J,      2'b10, 1, ea(A,0), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,0), 2'b11, 1, ea(A,1), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,1), 2'b11, 1, ea(A,2), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,2), 2'b11, 1, ea(A,3), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,3), 2'b00, 0, 32'h0,  0, 0, '0));
        tv.push_back(mk(1, 0, J,      2'b00, 0, 32'h0,  1, 1, L));
        tv.push_back(mk(1, 0, J,      2'b00, 0, 32'h0,  0, 1, L));
        tv.push_back(mk(1, 1, J,      2'b00, 0, 32'h0,  0, 0, '0));
        tv.push_back(mk(1, 0, J,      2'b10, 1, ea(A,0), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,0), 2'b11, 1, ea(A,1), 0, 0, '0));
        tv.push_back(mk(0, 0, wd(A,1), 2'b11, 1, ea(A,2), 0, 0, '0));
        tv.push_back(mk(1, 0, J,      2'b00, 1, 32'h0,  0, 1, '0));
        tv.push_back(mk(1, 1, J,      2'b00, 1, 32'h0,  0, 1, '0));
        tv.push_back(mk(1, 1, J,      2'b10, 1, ea(A,0), 0, 0, '0));
        tv.push_back(mk(1, 1, wd(A,0), 2'b11, 1, ea(A,1), 0, 0, '0));
        tv.push_back(mk(1, 1, wd(A,1), 2'b11, 1, ea(A,2), 0, 0, '0));
        tv.push_back(mk(1, 1, wd(A,2), 2'b11, 1, ea(A,3), 0, 0, '0));
        tv.push_back(mk(1, 1, wd(A,3), 2'b00, 0, 32'h0,  0, 0, '0));
        tv.push_back(mk(1, 1, J,      2'b00, 0, 32'h0,  1, 1, L));
        tv.push_back(mk(1, 1, J,      2'b00, 0, 32'h0,  0, 0, '0));
        tv.push_back(mk(1, 0, J,      2'b10, 1, ea(A,0), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,0), 2'b11, 1, ea(A,1), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,1), 2'b11, 1, ea(A,2), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,2), 2'b11, 1, ea(A,3), 0, 0, '0));
        tv.push_back(mk(1, 0, wd(A,3), 2'b00, 0, 32'h0,  0, 0, '0));
        tv.push_back(mk(1, 0, J,      2'b00, 0, 32'h0,  1, 1, L));
        tv.push_back(mk(1, 0, J,      2'b00, 0, 32'h0,  0, 1, L));

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset htrans", 128'(htrans), 128'(2'b00));
        chk("reset haddr", 128'(haddr), 128'(0));
        chk("reset hburst", 128'(hburst), 128'(3'b000));
        chk("reset mem_ready", 128'(mem_ready), 128'(0));
        chk("reset mem_err", 128'(mem_err), 128'(0));
        chk("reset data", mem_data_out, '0);
        chk("hsize", 128'(hsize), 128'(3'b010));
        chk("hwrite", 128'(hwrite), 128'(0));
        rst = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            if (i != 0) @(negedge clk);
            chk($sformatf("v%0d htrans", i), 128'(htrans), 128'(tv[i].ht));
            if (tv[i].ca) chk($sformatf("v%0d haddr", i), 128'(haddr), 128'(tv[i].ha));
            chk($sformatf("v%0d mem_ready", i), 128'(mem_ready), 128'(tv[i].mr));
            chk($sformatf("v%0d mem_err", i), 128'(mem_err), 128'(0));
            if (tv[i].cd) chk($sformatf("v%0d data", i), mem_data_out, tv[i].d);
            rst = tv[i].rst; mem_req = tv[i].req; mem_addr = A;
            hready = 1'b1; hresp = 1'b0; hrdata = tv[i].rdata;
        end

        // Two wait states in the second data phase: bus held, data unchanged
        @(negedge clk); drv(1, 1, 0, J);
        @(negedge clk); chk_bus("ws b0", 2'b10, ea(A,0)); chk("ws hburst", 128'(hburst), 128'(HB)); drv(0, 1, 0, J);
        @(negedge clk); chk_bus("ws b1", 2'b11, ea(A,1)); drv(0, 1, 0, wd(A,0));
        @(negedge clk); chk_bus("ws b2", 2'b11, ea(A,2)); drv(0, 0, 0, J);
        @(negedge clk); chk_bus("ws hold1", 2'b11, ea(A,2)); drv(0, 0, 0, J);
        @(negedge clk); chk_bus("ws hold2", 2'b11, ea(A,2)); drv(0, 1, 0, wd(A,1));
        @(negedge clk); chk_bus("ws b3", 2'b11, ea(A,3)); drv(0, 1, 0, wd(A,2));
        @(negedge clk); chk_bus("ws end", 2'b00, 32'h0); chk("ws early ready", 128'(mem_ready), 128'(0)); drv(0, 1, 0, wd(A,3));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            hrdata = J;
        end while (!mem_ready && n < 10);
        chk("ws latency", 128'(n), 128'(1));
        chk("ws data", mem_data_out, L);
        chk("ws mem_err", 128'(mem_err), 128'(0));
        @(negedge clk); chk("ws pulse width", 128'(mem_ready), 128'(0));

        // Two-cycle ERROR on the second data beat
        ed = '0;
        ed[{lane(A,0), 5'd0} +: 32] = wd(A,0);
        @(negedge clk); drv(1, 1, 0, J);
        @(negedge clk); chk_bus("er b0", 2'b10, ea(A,0)); drv(0, 1, 0, J);
        @(negedge clk); chk_bus("er b1", 2'b11, ea(A,1)); drv(0, 1, 0, wd(A,0));
        @(negedge clk); chk_bus("er b2", 2'b11, ea(A,2)); drv(0, 0, 1, J);
        @(negedge clk); chk_bus("er cycle2", 2'b00, 32'h0); chk("er early ready", 128'(mem_ready), 128'(0)); drv(0, 1, 1, J);
        @(negedge clk); chk("er mem_ready", 128'(mem_ready), 128'(1)); chk("er mem_err", 128'(mem_err), 128'(1));
        chk("er data", mem_data_out, ed); chk_bus("er done", 2'b00, 32'h0); drv(0, 1, 0, J);
        @(negedge clk); chk("er ready drop", 128'(mem_ready), 128'(0)); chk("er err drop", 128'(mem_err), 128'(0));
        chk_bus("er idle", 2'b00, 32'h0);
        @(negedge clk); chk_bus("er still idle", 2'b00, 32'h0); chk("er data held", mem_data_out, ed);

`ifdef CRITICAL_WORD_FIRST_EN
        begin
            logic [31:0] a6[4] = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
            logic [31:0] d6[4] = '{32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222};
            @(negedge clk); mem_req = 1'b1; mem_addr = 32'h1238; hready = 1'b1; hresp = 1'b0; hrdata = J;
            @(negedge clk); chk("cwf hburst", 128'(hburst), 128'(3'b010)); mem_req = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cwf b%0d htrans", k), 128'(htrans), 128'((k == 0) ? 2'b10 : 2'b11));
                chk($sformatf("cwf b%0d haddr", k), 128'(haddr), 128'(a6[k]));
                @(negedge clk);
                hrdata = d6[k];
            end
            @(negedge clk); hrdata = J;
            chk("cwf mem_ready", 128'(mem_ready), 128'(1));
            chk("cwf data", mem_data_out, L);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_line_fill.md
Name: ahb_line_fill

Overview:
Memory-side responder for the I-cache refill interface. It accepts a line-fill request (mem_req/mem_addr) from the cache and performs a 4-beat AHB-Lite read burst as bus master. It assembles the four 32-bit beats into one 128-bit line and returns it with a single-cycle mem_ready pulse. It sits between the cache's main-memory port and the system AHB bus.

Parameters:
LINE_WORDS, 4, words per line; fixed at 4 (128-bit line / 32-bit bus); other values unsupported.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous active-low reset.
mem_req  in  1  cache refill request; level; sampled only in IDLE.
mem_addr  in  32  requested address; byte address within line ignored except under option.
mem_data_out  out  128  assembled line; word w at [32*w+31:32*w]; valid while mem_ready=1, held until next fill completes.
mem_ready  out  1  one-cycle pulse: fill complete.
mem_err  out  1  one-cycle pulse coincident with mem_ready when the burst ended in ERROR.
haddr  out  32  AHB address.
htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11.
hburst  out  3  INCR4=011 (WRAP4=010 under option).
hsize  out  3  constant 010 (word).
hwrite  out  1  constant 0.
hrdata  in  32  AHB read data.
hready  in  1  AHB transfer-done.
hresp  in  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; htrans=00, haddr=0, hburst=000, beat counters=0, mem_ready=0, mem_err=0, mem_data_out=0. hsize=010 and hwrite=0 always. A reset mid-burst abandons the burst: no mem_ready pulse, and the line register is cleared.
- States: IDLE, BURST, DONE.
- IDLE: htrans=IDLE. When mem_req=1 at a posedge, latch base={mem_addr[31:4],4'b0000}. Drive NONSEQ, haddr=base, hburst=INCR4 from that edge; go to BURST.
- BURST: pipelined AHB.
  - The address-phase counter advances when hready=1. Beats 1-3 drive SEQ, haddr=base+4*beat.
  - After the 4th address phase is accepted, drive htrans=IDLE.
  - The data-phase counter captures hrdata into its word lane at each posedge with hready=1 and hresp=0.
  - When hready=0, haddr/htrans/hburst are held stable.
  - After the 4th data beat is captured, go to DONE.
- DONE: mem_ready=1 (and mem_err if flagged) for exactly one cycle, then IDLE. mem_req is ignored in DONE. A back-to-back request is sampled on the first IDLE edge, so there is a minimum 1 idle bus cycle between bursts.
- Zero-wait latency: request sampled at edge E0 → data captured at E2..E5 → mem_ready high in the cycle after E5.
- ERROR (hresp=1, first cycle hready=0): in the next cycle (second error cycle) drive htrans=IDLE. Remaining beats are cancelled; no further address phases are issued. Go to DONE with mem_err=1. Uncaptured lanes hold 0.
- If mem_req drops mid-burst, the burst still completes and mem_ready still pulses. The cache ignores the pulse.
- No back-pressure on mem_ready; the cache must sample it in the pulse cycle.

Optional Feature:
CRITICAL_WORD_FIRST_EN.
- Defined: hburst=WRAP4. The first beat is at {mem_addr[31:2],2'b00}; subsequent beats wrap within the 16-byte line. Each beat is stored in lane haddr[3:2], so mem_data_out layout is unchanged. mem_ready is still asserted only after all 4 beats.
- Undefined: INCR4 from the line-aligned base, as above.

Decomposition:
- Package ahb_pkg:
  - htrans_e enum (IDLE/BUSY/NONSEQ/SEQ).
  - hburst constants (SINGLE, INCR4, WRAP4).
  - HSIZE_WORD.
  - fill_state_e enum (IDLE/BURST/DONE).
  - LINE_W=128.
- No sub-module; a single module (address FSM plus line assembly register) is natural at this size.

Test Plan:
1. Zero-wait fill: mem_addr=0x0000_1234; slave returns words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → haddr 0x1230/1234/1238/123C with NONSEQ,SEQ,SEQ,SEQ; hburst=011; mem_ready one cycle after the 4th capture; mem_data_out=0x44444444_33333333_22222222_11111111; mem_err=0.
2. Wait states: same request, hready=0 for 2 cycles during beat 2 data phase → haddr/htrans held stable; mem_ready 2 cycles later than test 1; data identical.
3. ERROR on beat 1: hresp=1 with hready=0 then hready=1 → htrans=IDLE in the second error cycle; no beat 2/3 addresses; mem_ready=mem_err=1 for one cycle; lanes 1-3 = 0.
4. Reset mid-burst: rst=0 during beat 2 → at next posedge htrans=00, haddr=0, mem_data_out=0; mem_ready never pulses; a new request afterward fills normally.
5. Back-to-back fills with mem_req held high through DONE → second NONSEQ appears exactly one IDLE cycle after the mem_ready pulse. Also drop mem_req after beat 1 → burst completes and mem_ready pulses.
6. With CRITICAL_WORD_FIRST_EN: mem_addr=0x1238 → haddr 0x1238/123C/1230/1234, hburst=010; mem_data_out lanes match test 1 ordering.
